// File: rtl/udma_eth_rx_seq_if.sv
// Handshake bundle between the RX ring sequencer and the uDMA RX channel.
// The master side programs the channel; the slave side reports bytes remaining.
interface udma_eth_rx_seq_if #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
);
  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o;
  logic [TRANS_SIZE-1:0]     cfg_rx_size_o;
  logic                      cfg_rx_en_o;
  logic                      cfg_rx_clr_o;
  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i;

  modport master (
    output cfg_rx_startaddr_o, cfg_rx_size_o, cfg_rx_en_o, cfg_rx_clr_o,
    input  cfg_rx_bytes_left_i
  );

  modport slave (
    input  cfg_rx_startaddr_o, cfg_rx_size_o, cfg_rx_en_o, cfg_rx_clr_o,
    output cfg_rx_bytes_left_i
  );
endinterface

// File: rtl/udma_eth_rx_seq.sv
// RX buffer-ring sequencer: one L2 slot per Ethernet frame, frame lengths
// recorded in a status queue that software drains.
//
// state    | meaning
// IDLE     | ring disabled or configuration invalid
// ARM      | uDMA channel enabled for the current slot (release FIFO on re-arm)
// WAIT_EOF | frame in progress, waiting for rising edge of rx_eof_i
// DRAIN    | waiting for the RX FIFO to empty or the slot to fill
// COMMIT   | push status entry, clear channel, advance slot
// STALL    | status queue full, FIFO held blocked until software pops
module udma_eth_rx_seq #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int NUM_SLOTS      = 4,
  parameter int SLOT_LOG       = $clog2(NUM_SLOTS),
  parameter int FIFO_LOG       = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_base_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_slot_size_i,
  input  logic [SLOT_LOG:0]         cfg_num_slots_i,
  udma_eth_rx_seq_if.master         u_rx,
  input  logic                      rx_eof_i,
  input  logic [FIFO_LOG:0]         rx_fifo_elements_i,
  output logic                      rx_release_o,
  output logic                      stat_valid_o,
  output logic [TRANS_SIZE-1:0]     stat_len_o,
  output logic [SLOT_LOG-1:0]       stat_slot_o,
  output logic                      stat_trunc_o,
  input  logic                      stat_pop_i,
  output logic [SLOT_LOG:0]         stat_count_o,
  output logic                      busy_o
);
  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_EOF, S_DRAIN, S_COMMIT, S_STALL
  } state_t;

  localparam logic [SLOT_LOG:0] MAX_SLOTS = (SLOT_LOG+1)'(NUM_SLOTS);
  localparam int OFF_W = TRANS_SIZE + SLOT_LOG;

  state_t                    r_state;
  logic                      r_eof_q;
  logic                      r_en, r_clr, r_rel;
  logic [SLOT_LOG-1:0]       r_slot, r_head, r_tail;
  logic [SLOT_LOG:0]         r_count;
  logic [L2_AWIDTH_NOAL-1:0] r_startaddr;
  logic [TRANS_SIZE-1:0]     r_size;
  logic [TRANS_SIZE-1:0]     r_q_len  [NUM_SLOTS];
  logic [SLOT_LOG-1:0]       r_q_slot [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]      r_q_trunc;

  logic                      w_cfg_valid, w_eof_rise, w_push, w_pop, w_slot_last, w_drained;
  logic [SLOT_LOG-1:0]       w_slot_nxt;
  logic [OFF_W-1:0]          w_off;
  logic [L2_AWIDTH_NOAL-1:0] w_addr_nxt;
  logic [SLOT_LOG:0]         w_count_nxt;
  logic [TRANS_SIZE-1:0]     w_bytes_left;

  assign w_bytes_left = u_rx.cfg_rx_bytes_left_i;
  assign w_cfg_valid  = enable_i && (cfg_num_slots_i != '0) &&
                        (cfg_num_slots_i <= MAX_SLOTS) && (cfg_slot_size_i != '0);
  assign w_eof_rise   = rx_eof_i && !r_eof_q;
  assign w_drained    = (rx_fifo_elements_i == '0) || (w_bytes_left == '0);
  assign w_push       = (r_state == S_COMMIT) && enable_i;
  assign w_pop        = stat_pop_i && (r_count != '0);
  assign w_count_nxt  = r_count + (SLOT_LOG+1)'(w_push) - (SLOT_LOG+1)'(w_pop);
  assign w_slot_last  = ({1'b0, r_slot} == (cfg_num_slots_i - 1'b1));
  assign w_slot_nxt   = w_slot_last ? '0 : r_slot + 1'b1;
  assign w_off        = OFF_W'(w_slot_nxt) * OFF_W'(cfg_slot_size_i);
  // Slot address wraps inside the L2 window
  assign w_addr_nxt   = cfg_base_addr_i + L2_AWIDTH_NOAL'(w_off);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_eof_q     <= 1'b0;
      r_en        <= 1'b0;
      r_clr       <= 1'b0;
      r_rel       <= 1'b0;
      r_slot      <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_startaddr <= '0;
      r_size      <= '0;
    end else begin
      r_eof_q <= rx_eof_i;
      r_en    <= 1'b0;
      r_clr   <= 1'b0;
      r_rel   <= 1'b0;
      if (r_state != S_IDLE && !enable_i) begin
        r_clr   <= 1'b1;
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_state <= S_IDLE;
      end else begin
        if (w_pop) r_head <= r_head + 1'b1;
        if (w_push) begin
          r_q_len[r_tail]   <= cfg_slot_size_i - w_bytes_left;
          r_q_slot[r_tail]  <= r_slot;
          r_q_trunc[r_tail] <= (w_bytes_left == '0);
          r_tail            <= r_tail + 1'b1;
        end
        r_count <= w_count_nxt;
        case (r_state)
          S_IDLE: if (w_cfg_valid) begin
            r_slot      <= '0;
            r_startaddr <= cfg_base_addr_i;
            r_size      <= cfg_slot_size_i;
            r_en        <= 1'b1;
            r_state     <= S_ARM;
          end
          S_ARM:      r_state <= S_WAIT_EOF;
          S_WAIT_EOF: if (w_eof_rise) r_state <= S_DRAIN;
          S_DRAIN: if (w_drained) begin
            r_clr   <= 1'b1;
            r_state <= S_COMMIT;
          end
          S_COMMIT: begin
            r_slot      <= w_slot_nxt;
            r_startaddr <= w_addr_nxt;
            r_size      <= cfg_slot_size_i;
            if (w_count_nxt >= cfg_num_slots_i) begin
              r_state <= S_STALL;
            end else begin
              r_en    <= 1'b1;
              r_rel   <= 1'b1;
              r_state <= S_ARM;
            end
          end
          S_STALL: if (r_count < cfg_num_slots_i) begin
            r_en    <= 1'b1;
            r_rel   <= 1'b1;
            r_state <= S_ARM;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign u_rx.cfg_rx_startaddr_o = r_startaddr;
  assign u_rx.cfg_rx_size_o      = r_size;
  assign u_rx.cfg_rx_en_o        = r_en;
  assign u_rx.cfg_rx_clr_o       = r_clr;
  assign rx_release_o            = r_rel;

  // Queue storage is not reset, so head fields are masked while empty
  assign stat_valid_o = (r_count != '0);
  assign stat_len_o   = stat_valid_o ? r_q_len[r_head]   : '0;
  assign stat_slot_o  = stat_valid_o ? r_q_slot[r_head]  : '0;
  assign stat_trunc_o = stat_valid_o && r_q_trunc[r_head];
  assign stat_count_o = r_count;
  assign busy_o       = (r_state != S_IDLE);
endmodule

// File: tb/tb_udma_eth_rx_seq.sv
// Randomized bench for the RX ring sequencer against a frame-level model
// (slot counter, expected address arithmetic and a queue of status entries).
module tb_udma_eth_rx_seq;
  localparam int AW = 12, TS = 16, NS = 4, SL = 2, FL = 10;

  logic          clk_sys = 1'b0;
  logic          rst, enable, eof, pop;
  logic [AW-1:0] base;
  logic [TS-1:0] ssize;
  logic [SL:0]   nslots;
  logic [FL:0]   fifo;
  logic          rel, valid, trunc, busy;
  logic [TS-1:0] slen;
  logic [SL-1:0] sslot;
  logic [SL:0]   scount;

  udma_eth_rx_seq_if #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) u_if ();

  udma_eth_rx_seq #(
    .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .NUM_SLOTS(NS), .SLOT_LOG(SL), .FIFO_LOG(FL)
  ) u_dut (
    .clk_i(clk_sys), .rst_i(rst), .enable_i(enable),
    .cfg_base_addr_i(base), .cfg_slot_size_i(ssize), .cfg_num_slots_i(nslots),
    .u_rx(u_if),
    .rx_eof_i(eof), .rx_fifo_elements_i(fifo), .rx_release_o(rel),
    .stat_valid_o(valid), .stat_len_o(slen), .stat_slot_o(sslot), .stat_trunc_o(trunc),
    .stat_pop_i(pop), .stat_count_o(scount), .busy_o(busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {int slot; int len; int trunc;} ent_t;
  ent_t q[$];
  int m_base, m_size, m_n, m_slot;
  int n_chk = 0, n_err = 0;

  function automatic int addr_of(int s);
    return (m_base + s * m_size) & 'hFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic wait_en(input int budget);
    for (int i = 0; i < budget && !u_if.cfg_rx_en_o; i++) tick();
    chk("en_seen", u_if.cfg_rx_en_o, 1);
  endtask

  task automatic check_head();
    chk("stat_valid", valid, (q.size() > 0) ? 1 : 0);
    if (q.size() > 0) begin
      chk("stat_len", slen, q[0].len);
      chk("stat_slot", sslot, q[0].slot);
      chk("stat_trunc", trunc, q[0].trunc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_en"}, u_if.cfg_rx_en_o, 0);
    chk({tag, "_clr"}, u_if.cfg_rx_clr_o, 0);
    chk({tag, "_rel"}, rel, 0);
    chk({tag, "_addr"}, u_if.cfg_rx_startaddr_o, 0);
    chk({tag, "_size"}, u_if.cfg_rx_size_o, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_len"}, slen, 0);
    chk({tag, "_count"}, scount, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic pop_one();
    bit was_stall;
    was_stall = (q.size() == m_n);
    check_head();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    void'(q.pop_front());
    chk("pop_count", scount, q.size());
    if (was_stall) begin
      wait_en(4);
      chk("stall_exit_rel", rel, 1);
      chk("stall_exit_addr", u_if.cfg_rx_startaddr_o, addr_of(m_slot));
    end
  endtask

  task automatic start(input int b, input int s, input int n);
    base = AW'(b); ssize = TS'(s); nslots = (SL+1)'(n);
    m_base = b; m_size = s; m_n = n; m_slot = 0;
    enable = 1'b1;
    tick();
    chk("arm_en", u_if.cfg_rx_en_o, 1);
    chk("arm_no_rel", rel, 0);
    chk("arm_addr", u_if.cfg_rx_startaddr_o, b);
    chk("arm_size", u_if.cfg_rx_size_o, s);
    chk("arm_busy", busy, 1);
    tick();
    chk("arm_en_once", u_if.cfg_rx_en_o, 0);
  endtask

  task automatic disable_chk();
    enable = 1'b0;
    tick();
    chk("dis_clr", u_if.cfg_rx_clr_o, 1);
    chk("dis_count", scount, 0);
    chk("dis_busy", busy, 0);
    chk("dis_valid", valid, 0);
    tick();
    chk("dis_clr_once", u_if.cfg_rx_clr_o, 0);
    q.delete();
  endtask

  // One frame: eof edge, optional drain hold, commit, then re-arm or stall.
  task automatic run_frame(input int bl, input int hold, input bit simpop, input bit keep_eof);
    ent_t e;
    int   i;
    if (bl == 0) hold = 0;
    tick();
    u_if.cfg_rx_bytes_left_i = TS'(bl);
    fifo = (hold > 0 || bl == 0) ? (FL+1)'($urandom_range(1, 50)) : '0;
    eof = 1'b1;
    tick();
    if (!keep_eof) eof = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("drain_hold", u_if.cfg_rx_clr_o, 0);
      tick();
    end
    if (bl != 0) fifo = '0;
    i = 0;
    while (!u_if.cfg_rx_clr_o && i < 6) begin
      tick();
      i++;
    end
    chk("commit_clr", u_if.cfg_rx_clr_o, 1);
    e.slot  = m_slot;
    e.len   = (m_size - bl) & 'hFFFF;
    e.trunc = (bl == 0) ? 1 : 0;
    if (simpop && q.size() > 0) begin
      check_head();
      pop = 1'b1;
      void'(q.pop_front());
    end
    q.push_back(e);
    m_slot = (m_slot == m_n - 1) ? 0 : m_slot + 1;
    tick();
    pop = 1'b0;
    fifo = '0;
    chk("commit_count", scount, q.size());
    check_head();
    if (q.size() < m_n) begin
      chk("rearm_en", u_if.cfg_rx_en_o, 1);
      chk("rearm_rel", rel, 1);
      chk("rearm_addr", u_if.cfg_rx_startaddr_o, addr_of(m_slot));
      chk("rearm_size", u_if.cfg_rx_size_o, m_size);
    end else begin
      chk("stall_en", u_if.cfg_rx_en_o, 0);
      chk("stall_rel", rel, 0);
      chk("stall_busy", busy, 1);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("stall_hold", u_if.cfg_rx_en_o | rel, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; eof = 1'b0; pop = 1'b0; fifo = '0;
    base = '0; ssize = '0; nslots = '0;
    u_if.cfg_rx_bytes_left_i = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    start('h100, 64, 4);
    run_frame(24, 0, 1'b0, 1'b0);
    chk("f1_addr", u_if.cfg_rx_startaddr_o, 'h140);
    for (int f = 0; f < 3; f++) run_frame($urandom_range(1, 63), 0, 1'b0, 1'b0);
    pop_one();
    chk("wrap_addr", u_if.cfg_rx_startaddr_o, 'h100);
    repeat (3) pop_one();

    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(10, 3, 1'b0, 1'b0);
    run_frame(30, 0, 1'b1, 1'b0);
    chk("simpop_count", scount, 2);

    run_frame(20, 0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("eof_level_no_retrig", u_if.cfg_rx_clr_o, 0);
      chk("eof_level_count", scount, q.size());
    end
    eof = 1'b0;
    while (q.size() > 0) pop_one();
    disable_chk();

    for (int c = 0; c < 3; c++) begin
      nslots = (c == 0) ? 3'd5 : ((c == 1) ? 3'd0 : 3'd2);
      ssize  = (c == 2) ? 16'd0 : 16'd64;
      enable = 1'b1;
      repeat (4) tick();
      chk("bad_cfg_idle", busy | u_if.cfg_rx_en_o, 0);
      enable = 1'b0;
      tick();
    end

    for (int r = 0; r < 4; r++) begin
      start($urandom_range(0, 'hFFF), $urandom_range(1, 300), $urandom_range(1, NS));
      for (int f = 0; f < 10; f++) begin
        int npop, bl;
        if (q.size() == m_n) npop = $urandom_range(1, q.size());
        else npop = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, q.size());
        for (int p = 0; p < npop; p++) pop_one();
        bl = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, m_size);
        run_frame(bl, $urandom_range(0, 3), $urandom_range(0, 1) == 1, 1'b0);
      end
      disable_chk();
    end

    start('h200, 32, 4);
    run_frame(8, 0, 1'b0, 1'b0);
    tick();
    u_if.cfg_rx_bytes_left_i = 16'd5;
    fifo = 11'd7;
    eof = 1'b1;
    tick();
    eof = 1'b0;
    chk("drain_busy", busy, 1);
    rst = 1'b1;
    tick();
    check_all_zero("rst_drain");
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/udma_eth_rx_seq.md
Name: udma_eth_rx_seq

Overview:
- Hardware RX buffer-ring sequencer for the uDMA Ethernet-frame peripheral.
- Programs the uDMA RX channel with one L2 slot per frame and waits for end-of-frame.
- After the RX FIFO drains, records the frame length in a status queue, advances to the next slot and releases the blocked RX FIFO.
- Sits between the peripheral register file and the uDMA RX channel, so software only consumes status entries.

Parameters:
- L2_AWIDTH_NOAL, 12, L2 address width.
- TRANS_SIZE, 16, transfer-size width.
- NUM_SLOTS, 4, maximum ring slots and status queue depth (power of 2, ≥2).
- SLOT_LOG, $clog2(NUM_SLOTS), slot index width.
- FIFO_LOG, 10, width−1 of the RX FIFO element count.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- enable_i  in  1  level; ring operation enabled.
- cfg_base_addr_i  in  L2_AWIDTH_NOAL  ring base address.
- cfg_slot_size_i  in  TRANS_SIZE  bytes per slot.
- cfg_num_slots_i  in  SLOT_LOG+1  slots in use, valid range 1..NUM_SLOTS.
- cfg_rx_startaddr_o  out  L2_AWIDTH_NOAL  uDMA RX start address.
- cfg_rx_size_o  out  TRANS_SIZE  uDMA RX size.
- cfg_rx_en_o  out  1  one-cycle enable pulse.
- cfg_rx_clr_o  out  1  one-cycle clear pulse.
- cfg_rx_bytes_left_i  in  TRANS_SIZE  uDMA bytes remaining.
- rx_eof_i  in  1  end-of-frame flag from the frame path; acts on the rising edge.
- rx_fifo_elements_i  in  FIFO_LOG+1  RX FIFO fill level.
- rx_release_o  out  1  one-cycle pulse that clears FIFO blocked/eof.
- stat_valid_o  out  1  status queue not empty.
- stat_len_o  out  TRANS_SIZE  head entry frame length.
- stat_slot_o  out  SLOT_LOG  head entry slot index.
- stat_trunc_o  out  1  head entry truncated (slot filled).
- stat_pop_i  in  1  pop head entry.
- stat_count_o  out  SLOT_LOG+1  queue occupancy.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset:
  - FSM goes to IDLE; slot index, queue and count clear to 0.
  - All outputs reset to 0.
  - The rx_eof_i edge register clears to 0.
- cfg_valid condition: enable_i=1 and 1 ≤ cfg_num_slots_i ≤ NUM_SLOTS and cfg_slot_size_i ≠ 0.
- IDLE:
  - On cfg_valid: slot=0; register startaddr=cfg_base_addr_i and size=cfg_slot_size_i; go to ARM.
- ARM (1 cycle):
  - Pulse cfg_rx_en_o.
  - Pulse rx_release_o too, except on the first arm after IDLE.
  - Go to WAIT_EOF.
- WAIT_EOF:
  - Rising edge of rx_eof_i (previous 0, current 1) → DRAIN.
- DRAIN:
  - Exit to COMMIT when rx_fifo_elements_i==0 or cfg_rx_bytes_left_i==0.
- COMMIT (1 cycle):
  - Push {slot, len = cfg_slot_size_i − cfg_rx_bytes_left_i (TRANS_SIZE modulo), trunc = (bytes_left==0)}.
  - Pulse cfg_rx_clr_o.
  - Advance slot: slot = (slot==cfg_num_slots_i−1) ? 0 : slot+1.
  - Register startaddr = base + next_slot*slot_size, truncated to L2_AWIDTH_NOAL (wraps).
  - If the post-push count == cfg_num_slots_i → STALL, else → ARM.
- STALL:
  - The FIFO stays blocked (no release).
  - Leave to ARM in the cycle after count < cfg_num_slots_i.
- Disable:
  - enable_i=0 in any non-IDLE state pulses cfg_rx_clr_o once, flushes the queue (count=0) and goes to IDLE.
  - Disable has priority over every other transition, including a push in COMMIT.
- Status queue:
  - Circular FIFO of depth NUM_SLOTS; head outputs are combinational from the head entry.
  - Pop when empty is ignored.
  - Simultaneous push and pop: count is unchanged, head advances.
  - A push cannot overflow, because STALL gates re-arm.
- Latency:
  - From the IDLE cfg_valid cycle, cfg_rx_en_o pulses 1 cycle later.
  - From COMMIT, the stat entry is visible the next cycle and the re-arm en/release pulses come 1 cycle after COMMIT.
- Configuration is sampled only in IDLE and COMMIT; changes mid-frame take effect at the next COMMIT.

Test Plan:
- Basic arm: base=0x100, size=64, slots=4, enable → one cfg_rx_en_o pulse, startaddr=0x100, size=64, no release pulse.
- Frame commit: eof edge with fifo=0 and bytes_left=24 → stat len=40, slot=0, trunc=0, count=1; clr pulse, then en+release pulse, startaddr=0x140.
- Wrap and stall: 4 frames without pop → slots 0,1,2,3, count=4, FSM in STALL, no release; one pop → re-arm at slot 0, startaddr=0x100.
- Truncation and drain: eof with fifo=5 and bytes_left=0 → COMMIT with len=64, trunc=1; eof with fifo=3 and bytes_left≠0 → holds in DRAIN until fifo=0.
- Simultaneous push/pop: pop asserted in the COMMIT cycle with count=2 → count stays 2, head advances.
- Disable/reset mid-frame: enable_i=0 in WAIT_EOF → one clr pulse, count=0, IDLE; rst_i in DRAIN → all outputs 0 next cycle; a level-high eof held across re-arm does not retrigger.
